// File: rtl/pulse_cmd_decoder.sv
// Purpose : frames UART bytes into register-write commands, commits each payload
//           atomically to the pulse-parameter outputs and queues a one-byte ack.
// Latency : commit/rxd 1 cycle after the last payload byte (2 cycles after the
//           checksum byte when PULSE_CMD_CHECKSUM_EN is defined).
// Backpressure: none on rx (every rx_valid strobe is consumed); the ack is a
//           single-entry holding register, and a newer ack overwrites a pending one.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   rx_valid, rx_byte  received byte strobe and data
//   tx_ready           transmitter accepts the pending ack
//   tx_valid, tx_byte  pending ack byte (command byte, or 0xEE on checksum error)
//   per, p1wid, del, p2wid, p_bl, cp, bl   pulse parameters
//   rxd, err           one-cycle commit / error strobes
// Build option: PULSE_CMD_CHECKSUM_EN adds a trailing XOR checksum byte and a CHECK state.

module pulse_cmd_decoder #(
  parameter int          TIMEOUT = 120000,
  parameter logic [23:0] PER_RST = 24'd1200000,
  parameter logic [15:0] P1_RST  = 16'd30,
  parameter logic [15:0] DEL_RST = 16'd200,
  parameter logic [15:0] P2_RST  = 16'd60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  output logic [23:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [7:0]  p_bl,
  output logic        cp,
  output logic        bl,
  output logic        rxd,
  output logic        err
);

  localparam int GW = $clog2(TIMEOUT + 1);
  // Abort fires on the TIMEOUT-th consecutive idle cycle inside a command.
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT - 1);

`ifdef PULSE_CMD_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, PAYLOAD} state_t;
`endif

  state_t        state, state_d;
  logic [2:0]    cmd;
  logic [2:0]    remaining;
  logic [23:0]   staging;
  logic [GW-1:0] gap;

  logic          cmd_ok;
  logic [2:0]    cmd_len;
  logic          start, bad_cmd, shift, commit, timeout, fail;
  logic [23:0]   commit_dat;

`ifdef PULSE_CMD_CHECKSUM_EN
  logic [7:0]    csum;
  logic          chk_ok;
`endif

  assign cmd_ok = (rx_byte != 8'h00) && (rx_byte <= 8'h06);

  // Payload byte count per command; the checksum build expects one extra byte.
  always_comb begin
    cmd_len = 3'd1;
    case (rx_byte[2:0])
      3'd1:                cmd_len = 3'd3;
      3'd2, 3'd3, 3'd4:    cmd_len = 3'd2;
      default:             cmd_len = 3'd1;
    endcase
`ifdef PULSE_CMD_CHECKSUM_EN
    cmd_len = cmd_len + 3'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    start      = 1'b0;
    bad_cmd    = 1'b0;
    shift      = 1'b0;
    commit     = 1'b0;
    timeout    = 1'b0;
    fail       = 1'b0;
    commit_dat = staging;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (cmd_ok) begin
            start   = 1'b1;
            state_d = PAYLOAD;
          end else begin
            bad_cmd = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
`ifdef PULSE_CMD_CHECKSUM_EN
          // The final byte is the checksum; it is compared, not shifted in.
          shift = (remaining != 3'd1);
          if (remaining == 3'd1) state_d = CHECK;
`else
          shift = 1'b1;
          if (remaining == 3'd1) begin
            state_d    = IDLE;
            commit     = 1'b1;
            // Commit lands on this edge, so take the byte being shifted in now.
            commit_dat = {staging[15:0], rx_byte};
          end
`endif
        end else if (gap == GAP_MAX) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef PULSE_CMD_CHECKSUM_EN
      CHECK: begin
        state_d = IDLE;
        if (chk_ok) commit = 1'b1;
        else        fail   = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd       <= 3'd0;
      remaining <= 3'd0;
      staging   <= 24'd0;
      gap       <= '0;
      per       <= PER_RST;
      p1wid     <= P1_RST;
      del       <= DEL_RST;
      p2wid     <= P2_RST;
      p_bl      <= 8'd0;
      cp        <= 1'b0;
      bl        <= 1'b1;
      rxd       <= 1'b0;
      err       <= 1'b0;
      tx_valid  <= 1'b0;
      tx_byte   <= 8'd0;
`ifdef PULSE_CMD_CHECKSUM_EN
      csum      <= 8'd0;
      chk_ok    <= 1'b0;
`endif
    end else begin
      rxd <= commit;
      err <= bad_cmd | timeout | fail;

      if (start) begin
        cmd       <= rx_byte[2:0];
        remaining <= cmd_len;
        staging   <= 24'd0;
        gap       <= '0;
`ifdef PULSE_CMD_CHECKSUM_EN
        csum      <= rx_byte;
`endif
      end else if (state == PAYLOAD) begin
        if (rx_valid) begin
          remaining <= remaining - 3'd1;
          gap       <= '0;
          if (shift) begin
            staging <= {staging[15:0], rx_byte};
`ifdef PULSE_CMD_CHECKSUM_EN
            csum    <= csum ^ rx_byte;
`endif
          end
`ifdef PULSE_CMD_CHECKSUM_EN
          else begin
            chk_ok <= (csum == rx_byte);
          end
`endif
        end else begin
          gap <= gap + GW'(1);
        end
      end

      if (commit) begin
        case (cmd)
          3'd1: per   <= commit_dat;
          3'd2: p1wid <= commit_dat[15:0];
          3'd3: del   <= commit_dat[15:0];
          3'd4: p2wid <= commit_dat[15:0];
          3'd5: p_bl  <= commit_dat[7:0];
          3'd6: begin
            cp <= commit_dat[0];
            bl <= commit_dat[1];
          end
          default: ;
        endcase
      end

      // A fresh ack takes priority over the handoff of the pending one.
      if (commit || fail) begin
        tx_valid <= 1'b1;
        tx_byte  <= fail ? 8'hEE : {5'd0, cmd};
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule
